// File: rtl/fir_pkg.sv
// fir_pkg: shared width helpers and reset coefficient for the multichannel FIR.
// No ports. It provides acc_w(), ch_w() and tap_w() to size the datapath, and RST_COEF.
// RST_COEF is the value loaded into tap 0 of both banks at reset.
// All other taps reset to 0, so the filter passes samples through unchanged.
package fir_pkg;
    localparam int RST_COEF = 1;

    function automatic int acc_w(input int dw, input int cw, input int nt);
        return dw + cw + $clog2(nt);
    endfunction

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tap_w(input int nt);
        return $clog2(nt);
    endfunction
endpackage

// File: rtl/fir_pipe_mc_if.sv
// fir_pipe_mc_if: sample, coefficient and result bus of the multichannel FIR.
// Sample side:      in_valid, in_ch, in_data (signed).
// Coefficient side: coef_we, coef_addr, coef_wdata (signed), coef_swap.
// Result side:      out_valid, out_ch, out_data (signed, full precision).
// Modports: master drives samples and coefficients; slave is the filter.
interface fir_pipe_mc_if
    import fir_pkg::*;
#(
    parameter int N_TAPS      = 8,
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int N_CH        = 2
);
    localparam int ACC_WIDTH = acc_w(DATA_WIDTH, COEFF_WIDTH, N_TAPS);
    localparam int CH_W      = ch_w(N_CH);
    localparam int TAP_W     = tap_w(N_TAPS);

    logic                          in_valid;
    logic [CH_W-1:0]               in_ch;
    logic signed [DATA_WIDTH-1:0]  in_data;
    logic                          coef_we;
    logic [TAP_W-1:0]              coef_addr;
    logic signed [COEFF_WIDTH-1:0] coef_wdata;
    logic                          coef_swap;
    logic                          out_valid;
    logic [CH_W-1:0]               out_ch;
    logic signed [ACC_WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_ch, in_data, coef_we, coef_addr, coef_wdata, coef_swap,
        input  out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, coef_we, coef_addr, coef_wdata, coef_swap,
        output out_valid, out_ch, out_data
    );
endinterface

// File: rtl/fir_ch_delay.sv
// fir_ch_delay: sample history of one channel.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset.
//   shift_en     : shifts din into the history.
//   din          : incoming sample.
//   taps         : filter window, newest first; taps[0] is din.
// taps[0] is driven straight from din, so the window already holds the sample
// being accepted. Only the N_TAPS-1 older samples are stored in registers.
module fir_ch_delay #(
    parameter int N_TAPS     = 8,
    parameter int DATA_WIDTH = 18
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                shift_en,
    input  logic [DATA_WIDTH-1:0]               din,
    output logic [N_TAPS-1:0][DATA_WIDTH-1:0]   taps
);
    logic [N_TAPS-2:0][DATA_WIDTH-1:0] hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
        end else if (shift_en) begin
            hist[0] <= din;
            for (int k = 1; k < N_TAPS - 1; k++) hist[k] <= hist[k-1];
        end
    end

    assign taps = {hist, din};
endmodule

// File: rtl/fir_pipe_mc.sv
// fir_pipe_mc: time-multiplexed multichannel FIR with a 3-stage pipeline.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset.
//   bus (slave)  : sample in, coefficient write and swap, result out.
// S1 registers every product and the channel tag.
// S2 registers the lower-half and upper-half partial sums.
// S3 registers out_data.
// Coefficients take part only at S1, so a bank swap never alters a result already in flight.
module fir_pipe_mc
    import fir_pkg::*;
#(
    parameter int N_TAPS      = 8,
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int N_CH        = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fir_pipe_mc_if.slave  bus
);
    localparam int ACC_WIDTH = acc_w(DATA_WIDTH, COEFF_WIDTH, N_TAPS);
    localparam int CH_W      = ch_w(N_CH);
    localparam int PW        = DATA_WIDTH + COEFF_WIDTH;
    localparam int HALF      = N_TAPS / 2;

    logic signed [COEFF_WIDTH-1:0]     shadow [N_TAPS];
    logic signed [COEFF_WIDTH-1:0]     active [N_TAPS];
    logic [N_TAPS-1:0][DATA_WIDTH-1:0] win [N_CH];
    logic [N_TAPS-1:0][DATA_WIDTH-1:0] x;
    logic                              acc;
    logic signed [PW-1:0]              prod [N_TAPS];
    logic                              v1, v2;
    logic [CH_W-1:0]                   ch1, ch2;
    logic signed [ACC_WIDTH-1:0]       lo, hi, lo_n, hi_n;

    // Samples addressed to a channel that does not exist are ignored completely.
    assign acc = bus.in_valid && (32'(bus.in_ch) < N_CH);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        fir_ch_delay #(.N_TAPS(N_TAPS), .DATA_WIDTH(DATA_WIDTH)) u_delay (
            .clk      (clk),
            .reset_n  (reset_n),
            .shift_en (acc && bus.in_ch == CH_W'(c)),
            .din      (bus.in_data),
            .taps     (win[c])
        );
    end

    always_comb begin
        x = '0;
        for (int c = 0; c < N_CH; c++) x = (bus.in_ch == CH_W'(c)) ? win[c] : x;
    end

    always_comb begin
        lo_n = '0;
        hi_n = '0;
        for (int k = 0; k < HALF; k++) lo_n = lo_n + ACC_WIDTH'(prod[k]);
        for (int k = HALF; k < N_TAPS; k++) hi_n = hi_n + ACC_WIDTH'(prod[k]);
    end

    // The swap copies shadow as it was before this edge, so a write in the
    // same cycle reaches only the shadow bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                shadow[k] <= (k == 0) ? COEFF_WIDTH'(RST_COEF) : '0;
                active[k] <= (k == 0) ? COEFF_WIDTH'(RST_COEF) : '0;
            end
        end else begin
            if (bus.coef_swap) for (int k = 0; k < N_TAPS; k++) active[k] <= shadow[k];
            if (bus.coef_we) shadow[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            ch1           <= '0;
            ch2           <= '0;
            lo            <= '0;
            hi            <= '0;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_data  <= '0;
            for (int k = 0; k < N_TAPS; k++) prod[k] <= '0;
        end else begin
            v1            <= acc;
            v2            <= v1;
            bus.out_valid <= v2;
            if (acc) begin
                ch1 <= bus.in_ch;
                for (int k = 0; k < N_TAPS; k++) prod[k] <= $signed(x[k]) * active[k];
            end
            if (v1) begin
                ch2 <= ch1;
                lo  <= lo_n;
                hi  <= hi_n;
            end
            if (v2) begin
                bus.out_ch   <= ch2;
                bus.out_data <= lo + hi;
            end
        end
    end
endmodule

// File: tb/tb_fir_pipe_mc.sv
// tb_fir_pipe_mc: checks fir_pipe_mc with directed tables, corner-case sequences and random traffic.
// The reference model keeps each channel's history as a plain array and computes the dot product directly.
module tb_fir_pipe_mc;
    import fir_pkg::*;

    localparam int NT  = 8;
    localparam int DW  = 18;
    localparam int CW  = 18;
    localparam int NCH = 2;
    localparam int CHW = ch_w(NCH);
    localparam int TW  = tap_w(NT);

    typedef struct {
        int     due;
        int     ch;
        longint data;
    } exp_t;

    typedef struct {
        int     ch;
        longint d;
        longint exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;

    longint hist [NCH][NT];
    longint act [NT];
    longint shd [NT];
    exp_t   q[$];
    longint last_d;
    int     last_ch;
    vec_t   tbl [16];

    fir_pipe_mc_if #(.N_TAPS(NT), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_CH(NCH)) bus ();

    fir_pipe_mc #(.N_TAPS(NT), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_CH(NCH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    function automatic longint rnd_s18();
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        return longint'(r);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) for (int k = 0; k < NT; k++) hist[c][k] = 0;
        for (int k = 0; k < NT; k++) begin
            act[k] = (k == 0) ? 1 : 0;
            shd[k] = (k == 0) ? 1 : 0;
        end
        q.delete();
        last_d  = 0;
        last_ch = 0;
    endtask

    task automatic check_out();
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("out_valid", longint'(bus.out_valid), 1);
            chk("out_ch", longint'(bus.out_ch), q[0].ch);
            chk("out_data", longint'(bus.out_data), q[0].data);
            last_d  = q[0].data;
            last_ch = q[0].ch;
            void'(q.pop_front());
        end else begin
            chk("idle_valid", longint'(bus.out_valid), 0);
            chk("hold_data", longint'(bus.out_data), last_d);
            chk("hold_ch", longint'(bus.out_ch), last_ch);
        end
    endtask

    // One clock cycle. If ue is set, ex is the expected result for this sample
    // instead of the value computed by the model.
    task automatic step(input bit v, input int ch, input longint d, input bit we,
                        input int addr, input longint wd, input bit sw,
                        input bit ue, input longint ex);
        longint y;
        if (v && ch < NCH) begin
            for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = d;
            y = 0;
            for (int k = 0; k < NT; k++) y += act[k] * hist[ch][k];
            q.push_back('{cyc + 3, ch, ue ? ex : y});
        end
        if (sw) act = shd;
        if (we) shd[addr] = wd;
        bus.in_valid   = v;
        bus.in_ch      = CHW'(ch);
        bus.in_data    = DW'(d);
        bus.coef_we    = we;
        bus.coef_addr  = TW'(addr);
        bus.coef_wdata = CW'(wd);
        bus.coef_swap  = sw;
        @(posedge clk);
        cyc++;
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int ch, input longint d);
        step(1, ch, d, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_exp(input int ch, input longint d, input longint ex);
        step(1, ch, d, 0, 0, 0, 0, 1, ex);
    endtask

    task automatic wr(input int addr, input longint wd);
        step(0, 0, 0, 1, addr, wd, 0, 0, 0);
    endtask

    task automatic swap();
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", longint'(bus.out_valid), 0);
        chk("rst_data", longint'(bus.out_data), 0);
        chk("rst_ch", longint'(bus.out_ch), 0);
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b0;
        bus.coef_swap = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].ch  = i % 2;
            tbl[i].d   = (i % 2 == 0) ? 10 : -5;
            tbl[i].exp = (i % 2 == 0) ? 10 * (i / 2 + 1) : -5 * (i / 2 + 1);
        end
        bus.in_valid   = 1'b0;
        bus.in_ch      = '0;
        bus.in_data    = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.coef_swap  = 1'b0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("rst_valid", longint'(bus.out_valid), 0);
        chk("rst_data", longint'(bus.out_data), 0);
        chk("rst_ch", longint'(bus.out_ch), 0);
        #1;
        reset_n = 1'b1;

        // Reset banks pass samples straight through.
        send_exp(0, 7, 7);
        send_exp(0, -3, -3);
        idle(4);

        // Impulse response with coefficients 1..8.
        for (int i = 0; i < NT; i++) send(0, 0);
        for (int k = 0; k < NT; k++) wr(k, k + 1);
        swap();
        for (int i = 0; i < NT; i++) send_exp(0, (i == 0) ? 1 : 0, i + 1);
        idle(4);

        // Channel isolation with all-ones coefficients.
        for (int k = 0; k < NT; k++) wr(k, 1);
        swap();
        for (int i = 0; i < 2 * NT; i++) send(i % 2, 0);
        for (int i = 0; i < 16; i++) send_exp(tbl[i].ch, tbl[i].d, tbl[i].exp);
        idle(4);

        // A sample sent on the swap edge still uses the old bank.
        for (int i = 0; i < NT; i++) send(0, 1);
        for (int k = 0; k < NT; k++) wr(k, 2);
        step(1, 0, 1, 0, 0, 0, 1, 1, 8);
        send_exp(0, 1, 16);
        idle(4);

        // Extreme negative coefficients and samples: the result must not wrap.
        for (int k = 0; k < NT; k++) wr(k, -131072);
        swap();
        for (int i = 0; i < NT - 1; i++) send(1, -131072);
        send_exp(1, -131072, 64'sd137438953472);
        idle(4);

        // A write and a swap in the same cycle: the swap copies the shadow bank
        // as it was before the write.
        step(0, 0, 0, 1, 0, 3, 1, 0, 0);
        send(0, 1);
        swap();
        send(0, 1);
        idle(4);

        // Reset while two samples are in flight.
        send(0, 5);
        send(1, 6);
        do_reset();
        idle(6);
        send_exp(0, 9, 9);
        idle(4);

        // Random traffic, including coefficient writes and swaps.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)), rnd_s18(),
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, NT - 1)), rnd_s18(),
                 $urandom_range(0, 15) == 0, 0, 0);
        end
        idle(5);
        chk("drain", longint'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fir_pipe_mc.md
FIR_PIPE_MC -- requirements
Module: fir_pipe_mc

Interface
REQ-001 Parameter: N_TAPS, 8, number of taps; SHALL be even and >= 2.
REQ-002 Parameter: DATA_WIDTH, 18, signed sample width.
REQ-003 Parameter: COEFF_WIDTH, 18, signed coefficient width.
REQ-004 Parameter: N_CH, 2, number of time-multiplexed channels; SHALL be >= 1.
REQ-005 Derived widths: ACC_WIDTH = DATA_WIDTH+COEFF_WIDTH+$clog2(N_TAPS); CH_W = max(1,$clog2(N_CH)); TAP_W = $clog2(N_TAPS).
REQ-006 Port list, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample strobe.
- in_ch  in  CH_W  channel of the sample.
- in_data  in  DATA_WIDTH  signed sample.
- coef_we  in  1  shadow-bank write strobe.
- coef_addr  in  TAP_W  tap index.
- coef_wdata  in  COEFF_WIDTH  signed coefficient.
- coef_swap  in  1  one-cycle pulse; copies the shadow bank to the active bank.
- out_valid  out  1  result strobe.
- out_ch  out  CH_W  channel of the result.
- out_data  out  ACC_WIDTH  signed full-precision FIR result.

Function
REQ-007 Each channel SHALL own an N_TAPS-deep sample history x_ch[0..N_TAPS-1], where x_ch[0] is the newest sample.
REQ-008 An accepted sample (in_valid=1) SHALL shift only the history of channel in_ch; all other channels' histories SHALL hold.
REQ-009 Result for a sample: y = sum over k=0..N_TAPS-1 of c[k]*x[k], computed on the history that includes the new sample as x[0]; c is the active bank.
REQ-010 Samples with in_ch >= N_CH SHALL be dropped: no history change and no out_valid.
REQ-011 Pipeline stage S1 SHALL register all N_TAPS products and the channel tag.
REQ-012 Pipeline stage S2 SHALL register two partial sums: taps 0..N_TAPS/2-1 and taps N_TAPS/2..N_TAPS-1.
REQ-013 Pipeline stage S3 SHALL register out_data as the sum of the two partial sums.
REQ-014 Latency SHALL be exactly 3 cycles: in_valid at edge n produces out_valid at edge n+3.
REQ-015 out_ch SHALL equal the in_ch accepted 3 cycles earlier.
REQ-016 The block SHALL accept a valid sample every cycle, in any channel order, with no backpressure.
REQ-017 out_valid SHALL be a one-cycle strobe per accepted sample; out_data and out_ch SHALL hold their last values while out_valid=0.
REQ-018 All arithmetic SHALL be signed and full precision at ACC_WIDTH; no overflow is possible for any input.
REQ-019 coef_we SHALL write coef_wdata into shadow[coef_addr] only; the active bank SHALL be unaffected.
REQ-020 coef_swap SHALL copy the whole shadow bank into the active bank at the same edge.
REQ-021 A sample accepted on the same edge as coef_swap SHALL use the old active bank. The first sample after that edge SHALL use the new bank.
REQ-022 Coefficients SHALL be captured at S1, so a swap never changes a result already in flight.
REQ-023 coef_we and coef_swap in the same cycle: the swap copies the pre-write shadow contents, and the write lands in shadow only.
REQ-024 coef_we and coef_swap SHALL NOT stall or corrupt the sample stream.

Reset
REQ-025 While reset_n=0, all histories, pipeline registers, out_data and out_ch SHALL be 0, and out_valid SHALL be 0.
REQ-026 While reset_n=0, both coefficient banks SHALL be c[0]=1 and c[k]=0 for k>0, i.e. pure passthrough.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight samples. No out_valid SHALL occur until 3 cycles after the first post-reset sample.

Structure
REQ-028 A shared package fir_pkg SHALL hold the ACC_WIDTH and CH_W width functions and the default reset coefficient constant.
REQ-029 The per-channel history SHALL be the sub-module fir_ch_delay, instantiated N_CH times, with ports: shift enable, data in, tap vector out.
REQ-030 The product, partial-sum and final-sum pipeline, and both coefficient banks, SHALL live in fir_pipe_mc.

Verification
REQ-031 Reset passthrough: after reset, send ch0 samples 7, -3 on consecutive cycles -> out_data 7 then -3, each 3 cycles after its input, out_ch=0.
REQ-032 Impulse: load coefficients 1,2,3,...,8 and swap; send ch0 samples 1 followed by seven 0s -> out_data sequence 1,2,...,8.
REQ-033 Channel isolation: with coefficients all 1 (N_TAPS=8), interleave ch0=10 and ch1=-5 for 8 samples each -> ch0 results 10,20,...,80 and ch1 results -5,-10,...,-40.
REQ-034 Swap timing: ch0 history all 1s under the coefficients-all-1 bank; pulse coef_swap with in_valid on the same edge, shadow holding coefficients all 2 -> that result is 8, the next result is 16.
REQ-035 Extremes: coefficients all -2^17 and inputs all -2^17 on ch1 -> out_data 8*2^34, with no wrap at ACC_WIDTH=39.
REQ-036 Reset mid-stream: assert reset_n=0 while two samples are in flight -> no out_valid afterwards, and out_data=0.
